cam_rgb565_capture: RTL and testbench

- Front-end capture stage for the parallel camera port. Sits directly upstream of the RGB565-to-RGB888 expander.
- Samples the 8-bit camera bus on pclk and pairs bytes into 16-bit RGB565 pixels. Drives r5/g6/b5 with a one-cycle valid strobe.
- Tracks frame/line sync and pixel coordinates, and flags geometry errors.
- Frame-granular enable, so downstream stages only ever see whole frames.

---
 rtl/cam_rgb565_capture.sv | 135 +++++++++++++
 tb/tb_cam_rgb565_capture.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/cam_rgb565_capture.sv
// Parallel camera capture front end: pairs 8-bit bus bytes into RGB565 pixels,
// tracks vsync/href geometry, and reports per-line / per-frame errors.
module cam_rgb565_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int X_W      = 10,
  parameter int Y_W      = 9
) (
  input  logic           pclk,
  input  logic           rstn,
  input  logic           capture_en,
  input  logic           cam_vsync,
  input  logic           cam_href,
  input  logic [7:0]     cam_data,
  output logic [4:0]     r_port_5,
  output logic [5:0]     g_port_6,
  output logic [4:0]     b_port_5,
  output logic           pix_valid,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic           frame_start,
  output logic           frame_done,
  output logic           err_line,
  output logic           err_frame,
  input  logic           err_clr
);

  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;

  // One extra bit so the counters can hold H_ACTIVE / V_ACTIVE+1 exactly.
  localparam logic [X_W:0] H_ACT  = (X_W+1)'(H_ACTIVE);
  localparam logic [Y_W:0] V_ACT  = (Y_W+1)'(V_ACTIVE);
  localparam logic [Y_W:0] V_SAT  = (Y_W+1)'(V_ACTIVE + 1);

  state_t         state, state_nxt;
  logic           vsync_q, href_q, phase;
  logic [7:0]     hi;
  logic [X_W:0]   pix_cnt;
  logic [Y_W:0]   line_cnt, line_nxt;
  logic           vs_rise, vs_fall, href_fall, byte_en, line_live, room;
  logic           emit, ovf, line_bad;
  logic           fs_set, fd_set, ef_set;

  assign vs_rise   = ~vsync_q & cam_vsync;
  assign vs_fall   = vsync_q & ~cam_vsync;
  assign href_fall = (state == ACTIVE) & href_q & ~cam_href;
  assign byte_en   = (state == ACTIVE) & cam_href;
  assign line_live = line_cnt < V_ACT;
  assign room      = pix_cnt < H_ACT;
  assign emit      = byte_en & phase & line_live & room;
  assign ovf       = byte_en & phase & line_live & ~room;
  assign line_bad  = href_fall & line_live & (phase | (pix_cnt != H_ACT));

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Line end is folded into line_nxt so a coincident vsync rise sees it.
  always_comb begin
    state_nxt = state;
    fs_set    = 1'b0;
    fd_set    = 1'b0;
    ef_set    = 1'b0;
    line_nxt  = line_cnt;
    if (href_fall && line_cnt != V_SAT) line_nxt = line_cnt + 1'b1;
    case (state)
      IDLE:   if (cam_vsync) state_nxt = SYNC;
      SYNC:   if (vs_fall && capture_en) begin
                state_nxt = ACTIVE;
                fs_set    = 1'b1;
              end
      ACTIVE: if (vs_rise) begin
                state_nxt = SYNC;
                if (line_nxt == V_ACT) fd_set = 1'b1;
                else                   ef_set = 1'b1;
              end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      phase       <= 1'b0;
      hi          <= '0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      r_port_5    <= '0;
      g_port_6    <= '0;
      b_port_5    <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      err_line    <= 1'b0;
      err_frame   <= 1'b0;
    end else begin
      vsync_q     <= cam_vsync;
      href_q      <= cam_href;
      frame_start <= fs_set;
      frame_done  <= fd_set;
      pix_valid   <= emit;
      if (fs_set) begin
        line_cnt <= '0;
        phase    <= 1'b0;
        pix_cnt  <= '0;
      end else begin
        line_cnt <= line_nxt;
        if (href_fall) begin
          phase   <= 1'b0;
          pix_cnt <= '0;
        end else if (byte_en) begin
          phase <= ~phase;
          if (!phase) hi <= cam_data;
          if (emit)   pix_cnt <= pix_cnt + 1'b1;
        end
      end
      if (emit) begin
        r_port_5 <= hi[7:3];
        g_port_6 <= {hi[2:0], cam_data[7:5]};
        b_port_5 <= cam_data[4:0];
        pix_x    <= pix_cnt[X_W-1:0];
        pix_y    <= line_cnt[Y_W-1:0];
      end
      if (err_clr)                  err_line <= 1'b0;
      else if (ovf || line_bad)     err_line <= 1'b1;
      if (err_clr)                  err_frame <= 1'b0;
      else if (ef_set)              err_frame <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cam_rgb565_capture.sv
// Directed bench for cam_rgb565_capture with a 4x2 frame geometry.
module tb_cam_rgb565_capture;
  localparam int H = 4, V = 2, XW = 2, YW = 1;

  logic          pclk = 0, rstn = 0, capture_en = 1, cam_vsync = 0, cam_href = 0, err_clr = 0;
  logic [7:0]    cam_data = 0;
  logic [4:0]    r_port_5, b_port_5;
  logic [5:0]    g_port_6;
  logic          pix_valid, frame_start, frame_done, err_line, err_frame;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  int checks = 0, failures = 0;

  cam_rgb565_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .X_W(XW), .Y_W(YW)) dut (
    .pclk(pclk), .rstn(rstn), .capture_en(capture_en), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .r_port_5(r_port_5), .g_port_6(g_port_6),
    .b_port_5(b_port_5), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .frame_done(frame_done), .err_line(err_line),
    .err_frame(err_frame), .err_clr(err_clr));

  always #5 pclk = ~pclk;

  logic [7:0] bytes [8] = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
  logic [15:0] rgb_exp [4] = '{{5'd31, 6'd0, 5'd0}, {5'd0, 6'd63, 5'd0},
                               {5'd0, 6'd0, 5'd31}, {5'd31, 6'd63, 5'd31}};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin @(negedge pclk); @(posedge pclk); #1; end
  endtask

  task automatic vs(input logic v);
    @(negedge pclk); cam_vsync = v; @(posedge pclk); #1;
  endtask

  task automatic clr();
    @(negedge pclk); err_clr = 1; @(posedge pclk); #1;
    @(negedge pclk); err_clr = 0;
  endtask

  // Sends nb bytes; pixels below npix must be emitted on line y with the table colours.
  task automatic send_line(input int nb, input int y, input int npix);
    for (int i = 0; i < nb; i++) begin
      @(negedge pclk); cam_href = 1; cam_data = bytes[i % 8];
      @(posedge pclk); #1;
      if (i % 2 == 1 && (i / 2) < npix) begin
        chk("pix_valid", 32'(pix_valid), 32'd1);
        chk("pix_x", 32'(pix_x), 32'(i / 2));
        chk("pix_y", 32'(pix_y), 32'(y));
        chk("rgb", 32'({r_port_5, g_port_6, b_port_5}), 32'(rgb_exp[(i / 2) % 4]));
      end else begin
        chk("no_pix", 32'(pix_valid), 32'd0);
      end
    end
    @(negedge pclk); cam_href = 0; @(posedge pclk); #1;
    chk("valid_low_at_eol", 32'(pix_valid), 32'd0);
  endtask

  initial begin
    // Reset state
    cyc(2);
    chk("rst_rgb", 32'({r_port_5, g_port_6, b_port_5}), 32'd0);
    chk("rst_flags", 32'({pix_valid, frame_start, frame_done, err_line, err_frame}), 32'd0);
    chk("rst_xy", 32'({pix_x, pix_y}), 32'd0);
    @(negedge pclk); rstn = 1;

    // Clean 2-line frame
    vs(1); cyc(1); vs(0);
    chk("fs_pulse", 32'(frame_start), 32'd1);
    cyc(1);
    chk("fs_one_cycle", 32'(frame_start), 32'd0);
    send_line(8, 0, 4); cyc(2);
    send_line(8, 1, 4);
    chk("no_err_line", 32'(err_line), 32'd0);
    vs(1);
    chk("fd_pulse", 32'(frame_done), 32'd1);
    chk("no_err_frame", 32'(err_frame), 32'd0);
    cyc(1);
    chk("fd_one_cycle", 32'(frame_done), 32'd0);

    // Short line of 7 bytes, then err_clr
    vs(0);
    send_line(7, 0, 3);
    chk("short_err_line", 32'(err_line), 32'd1);
    clr();
    chk("err_clr", 32'(err_line), 32'd0);
    send_line(8, 1, 4);
    vs(1);
    chk("short_fd", 32'(frame_done), 32'd1);

    // Long line of 10 bytes
    vs(0);
    send_line(10, 0, 4);
    chk("long_err_line", 32'(err_line), 32'd1);
    send_line(8, 1, 4);
    vs(1);
    chk("long_fd", 32'(frame_done), 32'd1);
    clr();

    // Three-line frame
    vs(0);
    send_line(8, 0, 4); send_line(8, 1, 4); send_line(8, 0, 0);
    vs(1);
    chk("3l_no_fd", 32'(frame_done), 32'd0);
    chk("3l_err_frame", 32'(err_frame), 32'd1);
    clr();
    chk("3l_clr", 32'({err_line, err_frame}), 32'd0);

    // Frame skipped because capture_en was low at vsync fall
    @(negedge pclk); capture_en = 0;
    vs(0);
    chk("skip_no_fs", 32'(frame_start), 32'd0);
    @(negedge pclk); capture_en = 1;
    send_line(8, 0, 0); send_line(8, 1, 0);
    vs(1);
    chk("skip_no_fd", 32'(frame_done), 32'd0);
    vs(0);
    chk("next_fs", 32'(frame_start), 32'd1);
    send_line(8, 0, 4); send_line(8, 1, 4);
    vs(1);
    chk("next_fd", 32'(frame_done), 32'd1);
    chk("next_no_err", 32'({err_line, err_frame}), 32'd0);

    // Asynchronous reset mid-line
    vs(0);
    @(negedge pclk); cam_href = 1; cam_data = 8'hF8; @(posedge pclk); #1;
    @(negedge pclk); cam_data = 8'h00; @(posedge pclk); #1;
    chk("pre_rst_r", 32'(r_port_5), 32'd31);
    @(negedge pclk); cam_data = 8'h07; #2; rstn = 0; #1;
    chk("async_rgb", 32'({r_port_5, g_port_6, b_port_5}), 32'd0);
    chk("async_flags", 32'({pix_valid, frame_start, frame_done, err_line, err_frame, pix_x, pix_y}), 32'd0);
    @(negedge pclk); rstn = 1; cam_href = 0;
    send_line(8, 0, 0);
    vs(1); cyc(1); vs(0);
    chk("rst_fs", 32'(frame_start), 32'd1);
    send_line(8, 0, 4); send_line(8, 1, 4);
    vs(1);
    chk("rst_fd", 32'(frame_done), 32'd1);
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
